// File: rtl/event_flag_scheduler_pkg.sv
// event_flag_scheduler_pkg: shared FSM encoding and width helper for the event flag scheduler
package event_flag_scheduler_pkg;
  typedef enum logic {ST_IDLE, ST_OFFER} state_t;
  function automatic int clog2(input int v);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) w = ((1 << i) < v) ? i + 1 : w;
    return w;
  endfunction
endpackage

// File: rtl/event_flag_scheduler_rr_pick.sv
// rr_pick: round-robin winner among candidates, searching upward from ptr+1 with wrap
module rr_pick import event_flag_scheduler_pkg::*; #(
  parameter int N = 4,
  localparam int IDW = clog2(N)
) (
  input  logic [N-1:0]   cand,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);
  localparam logic [IDW:0] NW = (IDW + 1)'(N);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IDW:0]   start, first, sum;
  // rot[j] is candidate (ptr+1+j) mod N, so the lowest set bit is the winner
  always_comb begin
    dbl   = {cand, cand};
    start = {1'b0, ptr} + 1'b1;
    rot   = N'(dbl >> start);
    first = '0;
    for (int j = N - 1; j >= 0; j--) first = rot[j] ? (IDW + 1)'(j) : first;
    sum   = start + first;
    any   = |cand;
    idx   = IDW'((sum >= NW) ? sum - NW : sum);
  end
endmodule

// File: rtl/event_flag_scheduler.sv
// event_flag_scheduler: sticky event flags with overflow, offered round-robin over valid/ready
module event_flag_scheduler import event_flag_scheduler_pkg::*; #(
  parameter int N = 4,
  localparam int IDW = clog2(N)
) (
  input  logic           clk,
  input  logic           r,
  input  logic [N-1:0]   set_i,
  input  logic [N-1:0]   clr_i,
  input  logic [N-1:0]   mask_i,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  input  logic           evt_ready,
  output logic [N-1:0]   pending_o,
  output logic [N-1:0]   ovf_o
);
  state_t         state_q;
  logic [N-1:0]   flag_q, flag_d, ovf_q, ovf_d, cons, cand;
  logic [IDW-1:0] rr_ptr_q, win;
  logic           any, xfer;
  // a set arriving with the consume of the same bit is a fresh event, not an overflow
  always_comb begin
    xfer   = evt_valid & evt_ready;
    cons   = xfer ? {{(N - 1){1'b0}}, 1'b1} << evt_id : '0;
    flag_d = ~clr_i & (set_i | (flag_q & ~cons));
    ovf_d  = ~clr_i & (ovf_q | (set_i & flag_q & ~cons));
    cand   = flag_q & ~mask_i;
  end
  rr_pick #(.N(N)) u_pick (.cand(cand), .ptr(rr_ptr_q), .any(any), .idx(win));
  // clearing the offered flag while unaccepted withdraws the offer
  always_ff @(posedge clk) begin
    if (r) begin
      flag_q    <= '0;
      ovf_q     <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      rr_ptr_q  <= IDW'(N - 1);
      state_q   <= ST_IDLE;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
      if (state_q == ST_IDLE) begin
        if (any) begin
          evt_valid <= 1'b1;
          evt_id    <= win;
          state_q   <= ST_OFFER;
        end
      end else if (xfer) begin
        evt_valid <= 1'b0;
        rr_ptr_q  <= evt_id;
        state_q   <= ST_IDLE;
      end else if (clr_i[evt_id]) begin
        evt_valid <= 1'b0;
        state_q   <= ST_IDLE;
      end
    end
  end
  assign pending_o = flag_q;
  assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_event_flag_scheduler.sv
// tb_event_flag_scheduler: directed scenario checks of the event flag scheduler
module tb_event_flag_scheduler;
  logic       clk = 1'b0;
  logic       r = 1'b1;
  logic [3:0] set_i = '0, clr_i = '0, mask_i = '0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending_o, ovf_o;
  int         tests = 0, fails = 0, cnt;
  logic [1:0] ids [8];

  event_flag_scheduler #(.N(4)) dut (
    .clk(clk), .r(r), .set_i(set_i), .clr_i(clr_i), .mask_i(mask_i),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
    .pending_o(pending_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    r = 1'b1; set_i = '0; clr_i = '0; mask_i = '0; evt_ready = 1'b0;
    tick();
    tick();
    r = 1'b0;
  endtask

  task automatic collect(input int cycles);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (evt_valid) begin
        if (cnt < 8) ids[cnt] = evt_id;
        cnt++;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    set_i = 4'b0001; tick();
    set_i = '0; tick();
    tests++; if (evt_valid !== 1'b1) begin fails++; $display("FAIL reset_pre_offer: valid=%b exp 1", evt_valid); end
    r = 1'b1; tick(); r = 1'b0;
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", evt_valid); end
    tests++; if (pending_o !== 4'b0000) begin fails++; $display("FAIL reset_pending: got %b exp 0000", pending_o); end
    tests++; if (ovf_o !== 4'b0000) begin fails++; $display("FAIL reset_ovf: got %b exp 0000", ovf_o); end
    set_i = 4'b0100; tick();
    set_i = '0;
    tests++; if (evt_valid !== 1'b0 || pending_o !== 4'b0100) begin fails++; $display("FAIL latency_t1: valid=%b pending=%b exp 0 0100", evt_valid, pending_o); end
    tick();
    tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin fails++; $display("FAIL latency_t2: valid=%b id=%0d exp 1 2", evt_valid, evt_id); end
  endtask

  task automatic test_fairness();
    apply_reset();
    set_i = 4'b1111; tick();
    set_i = '0; evt_ready = 1'b1;
    collect(12);
    tests++; if (cnt !== 4) begin fails++; $display("FAIL fair_count: got %0d exp 4", cnt); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (ids[i] !== 2'(i)) begin fails++; $display("FAIL fair_order[%0d]: got %0d exp %0d", i, ids[i], i); end
    end
    tests++; if (pending_o !== 4'b0000) begin fails++; $display("FAIL fair_drain: got %b exp 0000", pending_o); end
    set_i = 4'b1111; tick();
    set_i = '0;
    collect(12);
    tests++; if (cnt !== 4 || ids[0] !== 2'd0 || ids[3] !== 2'd3) begin fails++; $display("FAIL fair_restart: cnt=%0d first=%0d last=%0d exp 4 0 3", cnt, ids[0], ids[3]); end
    evt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    apply_reset();
    set_i = 4'b0010; tick();
    set_i = '0; tick();
    set_i = 4'b0010; tick();
    set_i = '0;
    tests++; if (ovf_o !== 4'b0010) begin fails++; $display("FAIL ovf_set: got %b exp 0010", ovf_o); end
    collect(4);
    tests++; if (cnt !== 4 || ids[0] !== 2'd1 || ids[3] !== 2'd1 || pending_o !== 4'b0010) begin fails++; $display("FAIL ovf_single_offer: cnt=%0d id=%0d pending=%b exp 4 1 0010", cnt, ids[3], pending_o); end
    clr_i = 4'b0010; tick();
    clr_i = '0;
    tests++; if (ovf_o !== 4'b0000 || pending_o !== 4'b0000) begin fails++; $display("FAIL ovf_clear: ovf=%b pending=%b exp 0000 0000", ovf_o, pending_o); end
    tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL withdraw: valid=%b exp 0", evt_valid); end
    collect(3);
    tests++; if (cnt !== 0) begin fails++; $display("FAIL withdraw_stays: offers=%0d exp 0", cnt); end
  endtask

  task automatic test_stall();
    apply_reset();
    set_i = 4'b1000; tick();
    set_i = '0; tick();
    set_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin fails++; $display("FAIL stall_hold[%0d]: valid=%b id=%0d exp 1 3", i, evt_valid, evt_id); end
    end
    tests++; if (ovf_o !== 4'b0001) begin fails++; $display("FAIL stall_ovf: got %b exp 0001", ovf_o); end
    set_i = '0; evt_ready = 1'b1; tick();
    evt_ready = 1'b0;
    tests++; if (evt_valid !== 1'b0 || pending_o !== 4'b0001) begin fails++; $display("FAIL stall_accept: valid=%b pending=%b exp 0 0001", evt_valid, pending_o); end
    tick();
    tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin fails++; $display("FAIL stall_next: valid=%b id=%0d exp 1 0", evt_valid, evt_id); end
  endtask

  task automatic test_mask();
    apply_reset();
    mask_i = 4'b0001; set_i = 4'b0011; tick();
    set_i = '0; evt_ready = 1'b1;
    collect(8);
    tests++; if (cnt !== 1 || ids[0] !== 2'd1) begin fails++; $display("FAIL mask_only1: cnt=%0d id=%0d exp 1 1", cnt, ids[0]); end
    tests++; if (pending_o !== 4'b0001) begin fails++; $display("FAIL mask_latched: got %b exp 0001", pending_o); end
    mask_i = '0;
    collect(6);
    tests++; if (cnt !== 1 || ids[0] !== 2'd0) begin fails++; $display("FAIL mask_release: cnt=%0d id=%0d exp 1 0", cnt, ids[0]); end
    evt_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    set_i = 4'b0100; tick();
    set_i = 4'b0001; tick();
    tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin fails++; $display("FAIL simul_offer: valid=%b id=%0d exp 1 2", evt_valid, evt_id); end
    set_i = 4'b0100; evt_ready = 1'b1; tick();
    set_i = '0;
    tests++; if (pending_o !== 4'b0101 || ovf_o !== 4'b0000) begin fails++; $display("FAIL simul_flags: pending=%b ovf=%b exp 0101 0000", pending_o, ovf_o); end
    collect(8);
    tests++; if (cnt !== 2 || ids[0] !== 2'd0 || ids[1] !== 2'd2) begin fails++; $display("FAIL simul_order: cnt=%0d ids=%0d,%0d exp 2 0,2", cnt, ids[0], ids[1]); end
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_overflow();
    test_stall();
    test_mask();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
